// File: rtl/alu_mc.sv
// alu_mc: multi-cycle integer ALU for MIPS-style R-type functs.
// Shift/logic/add/sub/slt complete on the accepting edge. Multiply and divide
// iterate one bit per clock. Both use a shared 2*WIDTH accumulator and commit
// to HI/LO in a final FIN cycle.
module alu_mc #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             go,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [SHW-1:0]   shamt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             dz
);

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_t;

    state_t               state_q, state_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;     // product, or {remainder, quotient}
    logic [WIDTH-1:0]     op_q, op_d;       // multiplicand or divisor magnitude
    logic [SHW-1:0]       cnt_q, cnt_d;
    logic                 div_q, div_d;     // FIN commits a divide result
    logic                 pneg_q, pneg_d;   // negate product / quotient
    logic                 rneg_q, rneg_d;   // negate remainder
    logic [WIDTH-1:0]     out_q, out_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic                 done_q, done_d;
    logic                 dz_q, dz_d;

    // Operand sign handling for signed mult/div
    logic                 sgn, a_neg, b_neg;
    logic [WIDTH-1:0]     mag_a, mag_b;
    assign sgn   = (funct == 6'h18) || (funct == 6'h1A);
    assign a_neg = sgn & a[WIDTH-1];
    assign b_neg = sgn & b[WIDTH-1];
    assign mag_a = a_neg ? -a : a;
    assign mag_b = b_neg ? -b : b;

    // Multiplier step: add multiplicand into the upper half when the LSB is set
    logic [WIDTH:0]       mul_sum;
    assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                   + ({(WIDTH+1){acc_q[0]}} & {1'b0, op_q});

    // Restoring divider step: shift in the next dividend bit, subtract if it fits.
    // The remainder always fits in WIDTH bits, so modulo subtraction is exact.
    logic [WIDTH:0]       div_rs;
    logic                 div_ge;
    logic [WIDTH-1:0]     rem_nxt;
    assign div_rs  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign div_ge  = div_rs >= {1'b0, op_q};
    assign rem_nxt = div_ge ? (div_rs[WIDTH-1:0] - op_q) : div_rs[WIDTH-1:0];

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            op_q    <= '0;
            cnt_q   <= '0;
            div_q   <= 1'b0;
            pneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            out_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            pneg_q  <= pneg_d;
            rneg_q  <= rneg_d;
            out_q   <= out_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
        end
    end

    // Next-state logic: op dispatch in IDLE, iteration in MUL/DIV, commit in FIN
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        pneg_d  = pneg_q;
        rneg_d  = rneg_q;
        out_d   = out_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        dz_d    = dz_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (go) begin
                    done_d = 1'b1;
                    case (funct)
                        6'h00: out_d = a << shamt;
                        6'h02: out_d = a >> shamt;
                        6'h03: out_d = $signed(a) >>> shamt;
                        6'h04: out_d = a << b[SHW-1:0];
                        6'h06: out_d = a >> b[SHW-1:0];
                        6'h07: out_d = $signed(a) >>> b[SHW-1:0];
                        6'h10: out_d = hi_q;
                        6'h11: hi_d  = a;
                        6'h12: out_d = lo_q;
                        6'h13: lo_d  = a;
                        6'h20, 6'h21: out_d = a + b;
                        6'h22, 6'h23: out_d = a - b;
                        6'h24: out_d = a & b;
                        6'h25: out_d = a | b;
                        6'h26: out_d = a ^ b;
                        6'h27: out_d = ~(a | b);
                        6'h2A: out_d = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
                        6'h2B: out_d = {{(WIDTH-1){1'b0}}, a < b};
                        6'h18, 6'h19: begin
                            done_d  = 1'b0;
                            state_d = MUL;
                            acc_d   = {{WIDTH{1'b0}}, mag_b};
                            op_d    = mag_a;
                            cnt_d   = '0;
                            div_d   = 1'b0;
                            pneg_d  = a_neg ^ b_neg;
                            rneg_d  = 1'b0;
                        end
                        6'h1A, 6'h1B: begin
                            done_d = 1'b0;
                            div_d  = 1'b1;
                            cnt_d  = '0;
                            dz_d   = (b == '0);
                            if (b == '0) begin
                                // Divide by zero: stage {hi,lo} = {a, ones} for FIN
                                state_d = FIN;
                                acc_d   = {a, {WIDTH{1'b1}}};
                                pneg_d  = 1'b0;
                                rneg_d  = 1'b0;
                            end else begin
                                state_d = DIV;
                                acc_d   = {{WIDTH{1'b0}}, mag_a};
                                op_d    = mag_b;
                                pneg_d  = a_neg ^ b_neg;
                                rneg_d  = a_neg;
                            end
                        end
                        default: out_d = '0;
                    endcase
                end
            end
            MUL: begin
                acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == SHW'(WIDTH-1)) state_d = FIN;
            end
            DIV: begin
                acc_d = {rem_nxt, acc_q[WIDTH-2:0], div_ge};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == SHW'(WIDTH-1)) state_d = FIN;
            end
            FIN: begin
                state_d = IDLE;
                done_d  = 1'b1;
                if (div_q) begin
                    lo_d = pneg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
                    hi_d = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
                end else begin
                    {hi_d, lo_d} = pneg_q ? -acc_q : acc_q;
                end
            end
        endcase
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign out  = out_q;
    assign hi   = hi_q;
    assign lo   = lo_q;
    assign dz   = dz_q;

endmodule

// File: tb/tb_alu_mc.sv
// Directed testbench for alu_mc: a WIDTH=32 instance and a WIDTH=8 instance.
module tb_alu_mc;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        go;
    logic [5:0]  funct;
    logic [31:0] a, b;
    logic [4:0]  shamt;
    logic        busy, done, dz;
    logic [31:0] out, hi, lo;

    logic        go8;
    logic [5:0]  funct8;
    logic [7:0]  a8, b8;
    logic [2:0]  shamt8;
    logic        busy8, done8, dz8;
    logic [7:0]  out8, hi8, lo8;

    int n_checks = 0;
    int n_pass   = 0;
    int edges, bcnt, dones;

    always #5 clk = ~clk;

    alu_mc #(.WIDTH(32), .SHW(5)) u32 (
        .clk(clk), .rst_n(rst_n), .go(go), .funct(funct), .a(a), .b(b),
        .shamt(shamt), .busy(busy), .done(done), .out(out), .hi(hi),
        .lo(lo), .dz(dz)
    );

    alu_mc #(.WIDTH(8), .SHW(3)) u8 (
        .clk(clk), .rst_n(rst_n), .go(go8), .funct(funct8), .a(a8), .b(b8),
        .shamt(shamt8), .busy(busy8), .done(done8), .out(out8), .hi(hi8),
        .lo(lo8), .dz(dz8)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Issue one op on the 32-bit DUT and wait (bounded) for done; edges counts
    // rising edges from acceptance (accepting edge = 1) until done is visible.
    task automatic run32(input logic [5:0] f, input logic [31:0] av, input logic [31:0] bv,
                         input logic [4:0] sh, output int e, output int bc);
        funct = f; a = av; b = bv; shamt = sh; go = 1'b1;
        @(negedge clk);
        go = 1'b0; e = 1; bc = 0;
        while (done !== 1'b1 && e < 100) begin
            if (busy === 1'b1) bc++;
            @(negedge clk);
            e++;
        end
        check("done_seen32", {63'd0, done}, 64'd1);
    endtask

    task automatic run8(input logic [5:0] f, input logic [7:0] av, input logic [7:0] bv,
                        output int e);
        funct8 = f; a8 = av; b8 = bv; shamt8 = 3'd0; go8 = 1'b1;
        @(negedge clk);
        go8 = 1'b0; e = 1;
        while (done8 !== 1'b1 && e < 100) begin
            @(negedge clk);
            e++;
        end
        check("done_seen8", {63'd0, done8}, 64'd1);
    endtask

    initial begin
        rst_n = 1'b0; go = 1'b0; funct = '0; a = '0; b = '0; shamt = '0;
        go8 = 1'b0; funct8 = '0; a8 = '0; b8 = '0; shamt8 = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_out", {32'd0, out}, 64'd0);
        check("rst_hi", {32'd0, hi}, 64'd0);
        check("rst_lo", {32'd0, lo}, 64'd0);
        check("rst_dz", {63'd0, dz}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single-cycle ops
        run32(6'h20, 32'd7, 32'd5, 5'd0, edges, bcnt);
        check("add_out", {32'd0, out}, 64'd12);
        check("add_lat", edges, 1);
        check("add_busy", bcnt, 0);
        @(negedge clk);
        check("add_done_pulse", {63'd0, done}, 64'd0);
        run32(6'h03, 32'h8000_0000, 32'd0, 5'd4, edges, bcnt);
        check("sra_out", {32'd0, out}, 64'hF800_0000);
        run32(6'h02, 32'h8000_0000, 32'd0, 5'd31, edges, bcnt);
        check("srl_out", {32'd0, out}, 64'h1);
        run32(6'h04, 32'h1, 32'h24, 5'd0, edges, bcnt);
        check("sllv_out", {32'd0, out}, 64'h10);
        run32(6'h27, 32'h0F0F_0000, 32'h0000_00FF, 5'd0, edges, bcnt);
        check("nor_out", {32'd0, out}, 64'hF0F0_FF00);
        run32(6'h3F, 32'h1, 32'h1, 5'd0, edges, bcnt);
        check("bad_funct_out", {32'd0, out}, 64'h0);
        run32(6'h2A, 32'hFFFF_FFFF, 32'd1, 5'd0, edges, bcnt);
        check("slt_out", {32'd0, out}, 64'd1);
        run32(6'h2B, 32'hFFFF_FFFF, 32'd1, 5'd0, edges, bcnt);
        check("sltu_out", {32'd0, out}, 64'd0);

        // Multiply
        run32(6'h18, 32'hFFFF_FFFE, 32'd3, 5'd0, edges, bcnt);
        check("mult_hi", {32'd0, hi}, 64'hFFFF_FFFF);
        check("mult_lo", {32'd0, lo}, 64'hFFFF_FFFA);
        check("mult_lat", edges, 34);
        check("mult_busy", bcnt, 33);
        check("mult_out_held", {32'd0, out}, 64'd0);
        run32(6'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, edges, bcnt);
        check("multu_hi", {32'd0, hi}, 64'hFFFF_FFFE);
        check("multu_lo", {32'd0, lo}, 64'h0000_0001);

        // Divide
        run32(6'h1A, 32'hFFFF_FFF9, 32'd2, 5'd0, edges, bcnt);
        check("div_lo", {32'd0, lo}, 64'hFFFF_FFFD);
        check("div_hi", {32'd0, hi}, 64'hFFFF_FFFF);
        check("div_lat", edges, 34);
        run32(6'h1B, 32'd100, 32'd7, 5'd0, edges, bcnt);
        check("divu_lo", {32'd0, lo}, 64'd14);
        check("divu_hi", {32'd0, hi}, 64'd2);
        check("divu_dz", {63'd0, dz}, 64'd0);
        run32(6'h1A, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0, edges, bcnt);
        check("divneg_lo", {32'd0, lo}, 64'h8000_0000);
        check("divneg_hi", {32'd0, hi}, 64'h0);

        // Divide by zero, then a normal divide clears dz
        run32(6'h1B, 32'h1234, 32'd0, 5'd0, edges, bcnt);
        check("dz_lat", edges, 2);
        check("dz_hi", {32'd0, hi}, 64'h1234);
        check("dz_lo", {32'd0, lo}, 64'hFFFF_FFFF);
        check("dz_flag", {63'd0, dz}, 64'd1);
        run32(6'h1B, 32'd100, 32'd7, 5'd0, edges, bcnt);
        check("dz_cleared", {63'd0, dz}, 64'd0);
        check("dz_after_lo", {32'd0, lo}, 64'd14);

        // go in the done cycle is accepted: mfhi reads the just-committed hi
        check("b2b_in_done", {63'd0, done}, 64'd1);
        run32(6'h10, 32'd0, 32'd0, 5'd0, edges, bcnt);
        check("b2b_mfhi_out", {32'd0, out}, 64'd2);
        check("b2b_mfhi_lat", edges, 1);

        // mthi / mfhi / mtlo
        run32(6'h11, 32'h55, 32'd0, 5'd0, edges, bcnt);
        check("mthi_hi", {32'd0, hi}, 64'h55);
        check("mthi_out_held", {32'd0, out}, 64'd2);
        run32(6'h10, 32'd0, 32'd0, 5'd0, edges, bcnt);
        check("mfhi_out", {32'd0, out}, 64'h55);
        run32(6'h13, 32'h66, 32'd0, 5'd0, edges, bcnt);
        check("mtlo_lo", {32'd0, lo}, 64'h66);
        @(negedge clk);

        // Reset in the middle of a divide
        funct = 6'h1B; a = 32'd100; b = 32'd7; go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        repeat (10) @(negedge clk);
        check("mid_busy_before", {63'd0, busy}, 64'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_busy", {63'd0, busy}, 64'd0);
        check("mid_rst_hi", {32'd0, hi}, 64'd0);
        check("mid_rst_lo", {32'd0, lo}, 64'd0);
        check("mid_rst_out", {32'd0, out}, 64'd0);
        rst_n = 1'b1;
        dones = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) dones++;
        end
        check("mid_rst_no_done", dones, 0);
        run32(6'h20, 32'd1, 32'd2, 5'd0, edges, bcnt);
        check("post_rst_add", {32'd0, out}, 64'd3);
        @(negedge clk);

        // go held high through a multiply yields exactly one result
        funct = 6'h19; a = 32'd3; b = 32'd5; go = 1'b1;
        dones = 0; bcnt = 0;
        for (int i = 0; i < 45; i++) begin
            @(negedge clk);
            if (busy === 1'b1) bcnt++;
            if (done === 1'b1) begin
                dones++;
                go = 1'b0;
            end
        end
        go = 1'b0;
        check("hold_dones", dones, 1);
        check("hold_busy", bcnt, 33);
        check("hold_lo", {32'd0, lo}, 64'd15);
        check("hold_hi", {32'd0, hi}, 64'd0);

        // WIDTH=8 instance
        run8(6'h18, 8'hFE, 8'h03, edges);
        check("w8_mult_hi", {56'd0, hi8}, 64'hFF);
        check("w8_mult_lo", {56'd0, lo8}, 64'hFA);
        check("w8_mult_lat", edges, 10);
        run8(6'h1B, 8'd100, 8'd7, edges);
        check("w8_divu_lo", {56'd0, lo8}, 64'd14);
        check("w8_divu_hi", {56'd0, hi8}, 64'd2);
        check("w8_divu_lat", edges, 10);
        run8(6'h1A, 8'hF9, 8'h02, edges);
        check("w8_div_lo", {56'd0, lo8}, 64'hFD);
        check("w8_div_hi", {56'd0, hi8}, 64'hFF);
        run8(6'h1B, 8'h12, 8'h00, edges);
        check("w8_dz_lat", edges, 2);
        check("w8_dz_flag", {63'd0, dz8}, 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
